// File: rtl/rv_alu_if.sv
// Operand/result bundle between the execute stage and the RV32I ALU.
// The master drives operands and opcode; the slave (ALU) returns results.
interface rv_alu_if #(
    parameter int DWIDTH = 32,
    parameter int OPW    = 4
);
    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;
    logic [OPW-1:0]    alu_op;
    logic              in_valid;
    logic [DWIDTH-1:0] y;
    logic              zero;
    logic [DWIDTH-1:0] y_q;
    logic              zero_q;
    logic              out_valid;

    modport master (
        output a, b, alu_op, in_valid,
        input  y, zero, y_q, zero_q, out_valid
    );

    modport slave (
        input  a, b, alu_op, in_valid,
        output y, zero, y_q, zero_q, out_valid
    );
endinterface

// File: rtl/rv_alu.sv
// RV32I integer ALU: same-cycle result y/zero plus a one-cycle
// registered copy for pipelined consumers.
module rv_alu #(
    parameter int DWIDTH = 32,
    parameter int OPW    = 4
) (
    input logic    clk,
    input logic    rst_n,
    rv_alu_if.slave bus
);
    localparam int SHW = $clog2(DWIDTH);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(5);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(6);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(7);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(8);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(9);
    localparam logic [OPW-1:0] OP_A    = OPW'(10);
    localparam logic [OPW-1:0] OP_B    = OPW'(11);

    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;
    logic [SHW-1:0]    sh;
    logic [DWIDTH-1:0] res;
    logic              res_zero;
    logic              lt_s;
    logic              lt_u;

    assign a  = bus.a;
    assign b  = bus.b;
    // Only the low log2(DWIDTH) bits of b select the shift distance.
    assign sh = b[SHW-1:0];

    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    always_comb begin
        res = '0;
        case (bus.alu_op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLL:  res = a << sh;
            OP_SRL:  res = a >> sh;
            OP_SRA:  res = DWIDTH'($signed(a) >>> sh);
            OP_SLT:  res = {{(DWIDTH-1){1'b0}}, lt_s};
            OP_SLTU: res = {{(DWIDTH-1){1'b0}}, lt_u};
            OP_A:    res = a;
            OP_B:    res = b;
            default: res = '0;
        endcase
    end

    assign res_zero = (res == '0);
    assign bus.y    = res;
    assign bus.zero = res_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
        end
    end

    // Result registers hold their last captured value while in_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.y_q    <= '0;
            bus.zero_q <= 1'b0;
        end else if (bus.in_valid) begin
            bus.y_q    <= res;
            bus.zero_q <= res_zero;
        end
    end
endmodule

// File: tb/tb_rv_alu.sv
// Self-checking bench for rv_alu: directed boundary cases, registered
// path, asynchronous reset, and 10k random ops against a reference model.
module tb_rv_alu;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rv_alu_if #(.DWIDTH(32), .OPW(4)) bus ();

    rv_alu #(.DWIDTH(32), .OPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference model built from the arithmetic definitions of each op.
    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        longint unsigned wide;
        logic [31:0] r;
        sh = b % 32;
        case (op)
            4'd0: begin wide = longint'(a) + longint'(b); r = wide[31:0]; end
            4'd1: begin wide = 64'h1_0000_0000 + longint'(a) - longint'(b); r = wide[31:0]; end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin wide = longint'(a) * (64'd1 << sh); r = wide[31:0]; end
            4'd6: r = 32'(longint'(a) / (64'd1 << sh));
            4'd7: begin
                r = 32'(longint'(a) / (64'd1 << sh));
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            4'd8: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            4'd10: r = a;
            4'd11: r = b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic v);
        bus.alu_op   = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = v;
    endtask

    task automatic comb(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
        drive(op, a, b, 1'b0);
        #1;
        check(tag, bus.y, exp);
        check({tag, "_z"}, 32'(bus.zero), 32'(exp == 32'd0));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;
        logic [31:0] e;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        #2;
        check("rst_yq", bus.y_q, 32'd0);
        check("rst_zq", 32'(bus.zero_q), 32'd0);
        check("rst_ov", 32'(bus.out_valid), 32'd0);

        comb("add",   4'd0,  32'd0,          32'd1,          32'd1);
        comb("add_w", 4'd0,  32'hFFFF_FFFF,  32'd1,          32'd0);
        comb("sub",   4'd1,  32'd1,          32'd1,          32'd0);
        comb("sub_w", 4'd1,  32'd0,          32'd1,          32'hFFFF_FFFF);
        comb("and",   4'd2,  32'hFFFF_FFFF,  32'h1000,       32'h1000);
        comb("or",    4'd3,  32'd0,          32'h1000,       32'h1000);
        comb("xor",   4'd4,  32'hFFFF_FFFF,  32'h1000,       32'hFFFF_EFFF);
        comb("sll",   4'd5,  32'd1,          32'd1,          32'd2);
        comb("srl",   4'd6,  32'd2,          32'd1,          32'd1);
        comb("sra",   4'd7,  32'h8000_0000,  32'd1,          32'hC000_0000);
        comb("sll_hb",4'd5,  32'd1,          32'h21,         32'd2);
        comb("sra_0", 4'd7,  32'h8765_4321,  32'h20,         32'h8765_4321);
        comb("sra_31",4'd7,  32'h8000_0000,  32'd31,         32'hFFFF_FFFF);
        comb("srl_31",4'd6,  32'h8000_0000,  32'd31,         32'd1);
        comb("sll_31",4'd5,  32'd3,          32'd31,         32'h8000_0000);
        comb("slt",   4'd8,  32'hFFFF_FFFF,  32'd1,          32'd1);
        comb("slt_eq",4'd8,  32'h1234,       32'h1234,       32'd0);
        comb("sltu",  4'd9,  32'd0,          32'hFFFF_FFFF,  32'd1);
        comb("sltu_n",4'd9,  32'hFFFF_FFFF,  32'd1,          32'd0);
        comb("pass_a",4'd10, 32'd0,          32'd1,          32'd0);
        comb("pass_b",4'd11, 32'd0,          32'd1,          32'd1);
        comb("op15",  4'd15, 32'd0,          32'd1,          32'd0);
        comb("op12",  4'd12, 32'h55,         32'h66,         32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(4'd0, 32'd2, 32'd3, 1'b1);
        @(posedge clk);
        #1;
        check("reg_yq", bus.y_q, 32'd5);
        check("reg_ov", 32'(bus.out_valid), 32'd1);
        check("reg_zq", 32'(bus.zero_q), 32'd0);
        @(negedge clk);
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        check("hold_yq", bus.y_q, 32'd5);
        check("hold_ov", 32'(bus.out_valid), 32'd0);
        check("hold_zq", 32'(bus.zero_q), 32'd0);
        @(negedge clk);
        drive(4'd1, 32'd9, 32'd9, 1'b1);
        @(posedge clk);
        #1;
        check("cap_z_yq", bus.y_q, 32'd0);
        check("cap_z_zq", 32'(bus.zero_q), 32'd1);

        @(negedge clk);
        drive(4'd0, 32'd7, 32'd8, 1'b1);
        @(posedge clk);
        #1;
        check("pre_rst_yq", bus.y_q, 32'd15);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_yq", bus.y_q, 32'd0);
        check("arst_zq", 32'(bus.zero_q), 32'd0);
        check("arst_ov", 32'(bus.out_valid), 32'd0);
        drive(4'd0, 32'd4, 32'd5, 1'b1);
        #1;
        check("arst_y", bus.y, 32'd9);
        @(posedge clk);
        #1;
        check("rst_hold_yq", bus.y_q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_yq", bus.y_q, 32'd9);
        check("rel_ov", 32'(bus.out_valid), 32'd1);

        for (int i = 0; i < 10000; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 7) == 0) rb = 32'($urandom_range(0, 31));
            drive(rop, ra, rb, 1'b0);
            #1;
            e = ref_alu(rop, ra, rb);
            check($sformatf("rnd_op%0d", rop), bus.y, e);
            check("rnd_z", 32'(bus.zero), 32'(e == 32'd0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
